// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the decode/issue pipeline controller.
//   - state_e      : sequencer states (RUN / FLUSHING / DRAIN)
//   - NUM_REGS     : architectural register count tracked by the scoreboard
//   - REG_IDX_W    : width of a register index
//   - REG_ZERO     : hard-wired zero register, never tracked as busy
//   - is_real_reg  : true for any register other than x0
package pipeline_ctrl_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSHING = 2'd1,
        ST_DRAIN    = 2'd2
    } state_e;

    function automatic logic is_real_reg(input logic [REG_IDX_W-1:0] idx);
        return idx != REG_ZERO;
    endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   clk, srst             clock, synchronous active-high reset (clears all bits)
//   set_en, set_idx       mark a register busy on the next edge (x0 ignored)
//   clr_en, clr_idx       mark a register free on the next edge (x0 ignored)
//   rd_a_idx/rd_a_busy    source-1 lookup (registered busy state only)
//   rd_b_idx/rd_b_busy    source-2 lookup
//   rd_c_idx/rd_c_busy    destination lookup (WAW check)
module hazard_ctrl_scoreboard
    import pipeline_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] rd_a_idx,
    input  logic [REG_IDX_W-1:0] rd_b_idx,
    input  logic [REG_IDX_W-1:0] rd_c_idx,
    output logic                 rd_a_busy,
    output logic                 rd_b_busy,
    output logic                 rd_c_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                set_hit;
    logic                clr_hit;

    assign set_hit = set_en & is_real_reg(set_idx);
    assign clr_hit = clr_en & is_real_reg(clr_idx);

    // A set and a clear of the same register in one cycle cannot come from a
    // legal stream (issue is blocked while the destination is busy); if it
    // does happen, the newer allocation wins.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            assign busy_d[gi] = (set_hit && set_idx == REG_IDX_W'(gi)) ? 1'b1 :
                                (clr_hit && clr_idx == REG_IDX_W'(gi)) ? 1'b0 :
                                busy_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd_a_busy = busy_q[rd_a_idx];
    assign rd_b_busy = busy_q[rd_b_idx];
    assign rd_c_busy = busy_q[rd_c_idx];

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline sequencer between decode and issue/execute.
// Detects RAW/WAW hazards against a pending-write scoreboard, limits the
// number of outstanding writebacks, and sequences redirect flushes and fence
// drains.
// Ports:
//   CLK, RST                         clock, synchronous active-high reset
//   DECODE_VALID/RS1/RS2/RD          decode-stage instruction fields
//   DECODE_USE_RS1/USE_RS2/WR_RD     operand usage flags
//   WB_VALID, WB_RD                  writeback retiring this cycle
//   JMP_DO                           redirect taken (pulse)
//   FENCE_REQ                        decode holds a fence
//   MEM_WAIT                         memory not ready, pipeline frozen
//   STALL, FLUSH                     hold / clear fetch+decode registers
//   ISSUE                            decode instruction accepted this cycle
//   FENCE_DONE                       one-cycle drain-complete pulse
//   INFLIGHT                         outstanding writeback count
module hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter  int FLUSH_CYCLES = 2,
    parameter  int MAX_INFLIGHT = 4,
    localparam int INFL_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 DECODE_VALID,
    input  logic [REG_IDX_W-1:0] DECODE_RS1,
    input  logic [REG_IDX_W-1:0] DECODE_RS2,
    input  logic [REG_IDX_W-1:0] DECODE_RD,
    input  logic                 DECODE_USE_RS1,
    input  logic                 DECODE_USE_RS2,
    input  logic                 DECODE_WR_RD,
    input  logic                 WB_VALID,
    input  logic [REG_IDX_W-1:0] WB_RD,
    input  logic                 JMP_DO,
    input  logic                 FENCE_REQ,
    input  logic                 MEM_WAIT,
    output logic                 STALL,
    output logic                 FLUSH,
    output logic                 ISSUE,
    output logic                 FENCE_DONE,
    output logic [INFL_W-1:0]    INFLIGHT
);

    // The flush counter holds "cycles left after this one", so it only needs
    // to reach FLUSH_CYCLES-1.
    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [INFL_W-1:0] INFL_MAX  = INFL_W'(MAX_INFLIGHT);

    state_e              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [INFL_W-1:0]   inflight_q, inflight_d;

    logic rs1_busy, rs2_busy, rd_busy;
    logic hazard;
    logic stall_int, flush_int, issue_int, fdone_int;
    logic wr_alloc, wb_retire;

    hazard_ctrl_scoreboard u_scoreboard (
        .clk       (CLK),
        .srst      (RST),
        .set_en    (issue_int & DECODE_WR_RD),
        .set_idx   (DECODE_RD),
        .clr_en    (WB_VALID),
        .clr_idx   (WB_RD),
        .rd_a_idx  (DECODE_RS1),
        .rd_b_idx  (DECODE_RS2),
        .rd_c_idx  (DECODE_RD),
        .rd_a_busy (rs1_busy),
        .rd_b_busy (rs2_busy),
        .rd_c_busy (rd_busy)
    );

    // Hazard looks only at registered busy bits: a writeback in this cycle
    // does not unblock the decode instruction until the next cycle.
    assign hazard = DECODE_VALID &
                    ((DECODE_USE_RS1 & is_real_reg(DECODE_RS1) & rs1_busy) |
                     (DECODE_USE_RS2 & is_real_reg(DECODE_RS2) & rs2_busy) |
                     (DECODE_WR_RD   & is_real_reg(DECODE_RD)  & rd_busy)  |
                     (inflight_q == INFL_MAX));

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        stall_int = 1'b0;
        flush_int = 1'b0;
        issue_int = 1'b0;
        fdone_int = 1'b0;

        case (state_q)
            ST_RUN: begin
                stall_int = hazard | MEM_WAIT;
                issue_int = DECODE_VALID & ~hazard & ~MEM_WAIT & ~JMP_DO & ~FENCE_REQ;
                if (JMP_DO) begin
                    state_d = ST_FLUSHING;
                    fcnt_d  = FCNT_LOAD;
                end else if (FENCE_REQ) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FLUSHING: begin
                // MEM_WAIT deliberately ignored: the flush must clear decode.
                flush_int = 1'b1;
                if (JMP_DO) begin
                    fcnt_d = FCNT_LOAD;
                end else if (fcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                stall_int = 1'b1;
                if (JMP_DO) begin
                    // Redirect abandons the fence; no completion pulse.
                    state_d = ST_FLUSHING;
                    fcnt_d  = FCNT_LOAD;
                end else if (inflight_q == '0 && !MEM_WAIT) begin
                    fdone_int = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Writebacks at zero outstanding are ignored so the count never wraps.
    assign wr_alloc  = issue_int & DECODE_WR_RD & is_real_reg(DECODE_RD);
    assign wb_retire = WB_VALID & (inflight_q != '0);

    always_comb begin
        inflight_d = inflight_q;
        case ({wr_alloc, wb_retire})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_RUN;
            fcnt_q     <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            inflight_q <= inflight_d;
        end
    end

    assign STALL      = stall_int & ~RST;
    assign FLUSH      = flush_int & ~RST;
    assign ISSUE      = issue_int & ~RST;
    assign FENCE_DONE = fdone_int & ~RST;
    assign INFLIGHT   = inflight_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the stimulus process evaluates a
// behavioural model each cycle and queues the expected outputs; a monitor
// on the falling edge pops and compares.
module tb_hazard_ctrl;

    localparam int FC = 2;
    localparam int MI = 4;
    localparam int IW = $clog2(MI + 1);

    localparam int M_RUN   = 0;
    localparam int M_FLUSH = 1;
    localparam int M_DRAIN = 2;

    localparam int K_NONE  = 0;
    localparam int K_ISSUE = 1;
    localparam int K_FLUSH = 2;
    localparam int K_FDONE = 3;
    localparam int K_PEAK  = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          DECODE_VALID = 1'b0;
    logic [4:0]    DECODE_RS1 = '0, DECODE_RS2 = '0, DECODE_RD = '0;
    logic          DECODE_USE_RS1 = 1'b0, DECODE_USE_RS2 = 1'b0, DECODE_WR_RD = 1'b0;
    logic          WB_VALID = 1'b0;
    logic [4:0]    WB_RD = '0;
    logic          JMP_DO = 1'b0, FENCE_REQ = 1'b0, MEM_WAIT = 1'b0;
    logic          STALL, FLUSH, ISSUE, FENCE_DONE;
    logic [IW-1:0] INFLIGHT;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .MAX_INFLIGHT(MI)) dut (
        .CLK(CLK), .RST(RST),
        .DECODE_VALID(DECODE_VALID), .DECODE_RS1(DECODE_RS1), .DECODE_RS2(DECODE_RS2),
        .DECODE_RD(DECODE_RD), .DECODE_USE_RS1(DECODE_USE_RS1), .DECODE_USE_RS2(DECODE_USE_RS2),
        .DECODE_WR_RD(DECODE_WR_RD), .WB_VALID(WB_VALID), .WB_RD(WB_RD),
        .JMP_DO(JMP_DO), .FENCE_REQ(FENCE_REQ), .MEM_WAIT(MEM_WAIT),
        .STALL(STALL), .FLUSH(FLUSH), .ISSUE(ISSUE), .FENCE_DONE(FENCE_DONE),
        .INFLIGHT(INFLIGHT)
    );

    typedef struct {
        bit       rst, valid, u1, u2, wr, wb, jmp, fence, mw;
        bit [4:0] rs1, rs2, rd, wbrd;
    } stim_t;

    typedef struct {
        bit stall, flush, issue, fdone, chk_infl, clr;
        int inflight, cyc, kind, want;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: set of registers awaiting writeback, outstanding count,
    // and the sequencer mode with flush cycles remaining (including current).
    bit busy_m[32];
    int infl_m, mode_m, flush_left_m;
    int cyc_no;
    int pend_kind, pend_want;
    bit pend_clr;
    bit done;

    // Monitor-owned counters.
    int n_checks, n_fail;
    int st_issue, st_flush, st_fdone, st_peak;
    exp_t me;

    function automatic stim_t mk(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wr);
        stim_t s;
        s = '{default: 0};
        s.valid = v; s.rs1 = 5'(rs1); s.u1 = u1; s.rs2 = 5'(rs2); s.u2 = u2;
        s.rd = 5'(rd); s.wr = wr;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic stim_t writer(int rd);
        return mk(1, 0, 0, 0, 0, rd, 1);
    endfunction

    function automatic stim_t reader(int rs, int rd);
        return mk(1, rs, 1, 0, 0, rd, 1);
    endfunction

    function automatic stim_t with_wb(stim_t s, int r);
        stim_t t = s;
        t.wb = 1; t.wbrd = 5'(r);
        return t;
    endfunction

    function automatic stim_t rst_stim();
        stim_t t = idle();
        t.rst = 1;
        return t;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   haz;
        int   old;
        @(posedge CLK);
        #1;
        RST = s.rst; DECODE_VALID = s.valid; DECODE_RS1 = s.rs1; DECODE_RS2 = s.rs2;
        DECODE_RD = s.rd; DECODE_USE_RS1 = s.u1; DECODE_USE_RS2 = s.u2; DECODE_WR_RD = s.wr;
        WB_VALID = s.wb; WB_RD = s.wbrd; JMP_DO = s.jmp; FENCE_REQ = s.fence; MEM_WAIT = s.mw;

        e = '{default: 0};
        e.cyc = cyc_no; cyc_no++;
        e.clr = pend_clr; e.kind = pend_kind; e.want = pend_want;
        pend_clr = 0; pend_kind = K_NONE; pend_want = 0;

        if (s.rst) begin
            // Outputs forced low; the counter's pre-edge value is not checked.
            e.chk_infl = 0;
            foreach (busy_m[i]) busy_m[i] = 0;
            infl_m = 0; mode_m = M_RUN; flush_left_m = 0;
        end else begin
            haz = s.valid && ((s.u1 && s.rs1 != 0 && busy_m[s.rs1]) ||
                              (s.u2 && s.rs2 != 0 && busy_m[s.rs2]) ||
                              (s.wr && s.rd  != 0 && busy_m[s.rd])  ||
                              (infl_m == MI));
            if (mode_m == M_RUN) begin
                e.stall = haz || s.mw;
                e.issue = s.valid && !haz && !s.mw && !s.jmp && !s.fence;
            end else if (mode_m == M_FLUSH) begin
                e.flush = 1;
            end else begin
                e.stall = 1;
                e.fdone = !s.jmp && infl_m == 0 && !s.mw;
            end
            e.chk_infl = 1;
            e.inflight = infl_m;

            old = infl_m;
            if (s.wb && s.wbrd != 0) busy_m[s.wbrd] = 0;
            if (e.issue && s.wr && s.rd != 0) begin
                busy_m[s.rd] = 1;
                infl_m++;
            end
            if (s.wb && old > 0) infl_m--;

            if (s.jmp) begin
                mode_m = M_FLUSH;
                flush_left_m = FC;
            end else if (mode_m == M_RUN) begin
                if (s.fence) mode_m = M_DRAIN;
            end else if (mode_m == M_FLUSH) begin
                flush_left_m--;
                if (flush_left_m == 0) mode_m = M_RUN;
            end else if (e.fdone) begin
                mode_m = M_RUN;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compares each queued expectation on the falling edge.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            n_checks++;
            if (STALL !== me.stall || FLUSH !== me.flush || ISSUE !== me.issue ||
                FENCE_DONE !== me.fdone || (me.chk_infl && int'(INFLIGHT) != me.inflight)) begin
                n_fail++;
                $display("FAIL outputs cyc%0d: got stall=%b flush=%b issue=%b fdone=%b infl=%0d, expected stall=%b flush=%b issue=%b fdone=%b infl=%0d",
                         me.cyc, STALL, FLUSH, ISSUE, FENCE_DONE, INFLIGHT,
                         me.stall, me.flush, me.issue, me.fdone, me.inflight);
            end else begin
                $display("cyc %0d: stall=%b flush=%b issue=%b fdone=%b infl=%0d ok",
                         me.cyc, STALL, FLUSH, ISSUE, FENCE_DONE, INFLIGHT);
            end
            if (me.clr) begin
                st_issue = 0; st_flush = 0; st_fdone = 0; st_peak = 0;
            end
            if (ISSUE === 1'b1)      st_issue++;
            if (FLUSH === 1'b1)      st_flush++;
            if (FENCE_DONE === 1'b1) st_fdone++;
            if (int'(INFLIGHT) > st_peak) st_peak = int'(INFLIGHT);
            if (me.kind != K_NONE) begin
                int got;
                got = (me.kind == K_ISSUE) ? st_issue :
                      (me.kind == K_FLUSH) ? st_flush :
                      (me.kind == K_FDONE) ? st_fdone : st_peak;
                n_checks++;
                if (got != me.want) begin
                    n_fail++;
                    $display("FAIL scenario_count kind%0d cyc%0d: got %0d, expected %0d",
                             me.kind, me.cyc, got, me.want);
                end else begin
                    $display("cyc %0d: scenario count kind%0d = %0d ok", me.cyc, me.kind, got);
                end
            end
        end else if (done) begin
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic mark(input int kind, input int want);
        pend_kind = kind;
        pend_want = want;
    endtask

    initial begin
        stim_t s;
        int    cand[$];
        done = 0; pend_clr = 0; pend_kind = K_NONE; pend_want = 0;

        // 1: RAW on x5 stalls until the cycle after its writeback.
        pend_clr = 1; step(rst_stim()); step(rst_stim());
        step(writer(5));
        repeat (3) step(reader(5, 6));
        step(with_wb(reader(5, 6), 5));
        step(reader(5, 6));
        mark(K_ISSUE, 2); step(idle());
        step(with_wb(idle(), 6));

        // 2: x0 is never busy; WB to x0 still retires one outstanding write.
        step(rst_stim());
        step(mk(1, 0, 1, 0, 1, 0, 1));
        step(writer(7));
        step(with_wb(idle(), 0));
        step(reader(7, 8));
        step(with_wb(reader(7, 8), 7));
        step(reader(7, 8));
        step(with_wb(idle(), 8));

        // 3: redirect during a stall, re-redirect in the second flush cycle.
        pend_clr = 1; step(rst_stim());
        step(writer(9));
        step(reader(9, 3));
        s = reader(9, 3); s.jmp = 1; step(s);
        step(reader(9, 3));
        s = reader(9, 3); s.jmp = 1; step(s);
        step(reader(9, 3));
        step(reader(9, 3));
        step(with_wb(reader(9, 3), 9));
        step(reader(9, 3));
        mark(K_FLUSH, 4); step(with_wb(idle(), 3));

        // 4: outstanding-write limit.
        pend_clr = 1; step(rst_stim());
        for (int r = 1; r <= 4; r++) step(writer(r));
        repeat (2) step(writer(10));
        step(with_wb(writer(10), 1));
        step(with_wb(writer(10), 2));
        step(with_wb(idle(), 3));
        step(with_wb(idle(), 4));
        mark(K_PEAK, 4); step(with_wb(idle(), 10));

        // 5: fence drain held by MEM_WAIT, then a single completion pulse.
        pend_clr = 1; step(rst_stim());
        step(writer(11));
        step(writer(12));
        s = idle(); s.fence = 1; s.mw = 1;
        step(s); step(s); step(s);
        step(with_wb(s, 11));
        step(with_wb(s, 12));
        step(s);
        s.mw = 0; step(s);
        mark(K_FDONE, 1); step(idle());

        // 6: reset while flushing with busy registers.
        step(rst_stim());
        step(writer(13));
        step(writer(14));
        s = idle(); s.jmp = 1; step(s);
        pend_clr = 1; step(rst_stim());
        mark(K_ISSUE, 1); step(reader(13, 15));

        // Randomised traffic against the model.
        step(rst_stim());
        for (int n = 0; n < 1500; n++) begin
            s = mk($urandom_range(99) < 70, $urandom_range(7), $urandom_range(1),
                   $urandom_range(7), $urandom_range(1), $urandom_range(7), $urandom_range(1));
            s.jmp   = $urandom_range(99) < 5;
            s.fence = $urandom_range(99) < 5;
            s.mw    = $urandom_range(99) < 15;
            cand.delete();
            for (int r = 1; r < 32; r++) if (busy_m[r]) cand.push_back(r);
            if (cand.size() > 0 && $urandom_range(99) < 40) begin
                s.wb   = 1;
                s.wbrd = 5'(cand[$urandom_range(cand.size() - 1)]);
            end
            s.rst = $urandom_range(149) == 0;
            step(s);
        end

        @(posedge CLK);
        #1;
        done = 1;
    end

endmodule
